// File: rtl/pdm_cic_recv.sv
// pdm_cic_recv: PDM microphone front end with CIC decimation.
//   Generates the microphone clock, captures one or two interleaved channels
//   from a shared data line (ch0 just before the pdm_clk rise, ch1 just before
//   the fall), runs an ORDER-stage CIC decimator per channel and presents
//   signed PCM frames on a valid/ready handshake with sticky overrun.
// Ports:
//   clk, resetn    system clock, asynchronous active-low reset
//   enable         run control; low clears the datapath synchronously
//   pdm_clk        microphone clock (registered)
//   pdm_data       shared PDM data line (asynchronous to clk)
//   sample_data    {ch1, ch0}, OUT_WIDTH bits each, ch0 in the low bits
//   sample_valid   frame available
//   sample_ready   consumer accepts the frame
//   overrun        sticky: a frame was replaced before it was accepted

// One CIC channel: integrators at the PDM rate, combs at the frame rate.
module pdm_cic_chan #(
    parameter int ORDER     = 3,
    parameter int W         = 20,
    parameter int OUT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear_i,
    input  logic                 cap_i,
    input  logic                 bit_i,
    input  logic                 comb_i,
    output logic [OUT_WIDTH-1:0] res_o
);
    localparam int SH = (W > OUT_WIDTH) ? W - OUT_WIDTH : 0;

    logic [ORDER-1:0][W-1:0] integ_q, integ_d, dly_q, dly_d;
    logic [ORDER:0][W-1:0]   cx;
    logic signed [W-1:0]     y;
    logic [OUT_WIDTH-1:0]    res_q, res_d;

    // Integrators wrap modulo 2^W; the combs undo the wrap exactly.
    always_comb begin
        integ_d = integ_q;
        if (cap_i) begin
            integ_d[0] = integ_q[0] + (bit_i ? W'(1) : '1);
            for (int k = 1; k < ORDER; k++)
                integ_d[k] = integ_q[k] + integ_d[k-1];
        end
    end

    // Comb chain, differential delay 1: each stage subtracts its previous input.
    always_comb begin
        cx[0] = integ_q[ORDER-1];
        for (int k = 0; k < ORDER; k++)
            cx[k+1] = cx[k] - dly_q[k];
        dly_d = dly_q;
        res_d = res_q;
        if (comb_i) begin
            for (int k = 0; k < ORDER; k++)
                dly_d[k] = cx[k];
            // Signed cast sign-extends when W <= OUT_WIDTH, otherwise the
            // arithmetic shift keeps the top OUT_WIDTH bits.
            res_d = OUT_WIDTH'(y >>> SH);
        end
    end

    assign y     = cx[ORDER];
    assign res_o = res_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            integ_q <= '0;
            dly_q   <= '0;
            res_q   <= '0;
        end else if (clear_i) begin
            integ_q <= '0;
            dly_q   <= '0;
            res_q   <= '0;
        end else begin
            integ_q <= integ_d;
            dly_q   <= dly_d;
            res_q   <= res_d;
        end
    end
endmodule

module pdm_cic_recv #(
    parameter int CHANNELS  = 2,
    parameter int CLK_DIV   = 64,
    parameter int ORDER     = 3,
    parameter int DECIM     = 64,
    parameter int OUT_WIDTH = 24
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          enable,
    output logic                          pdm_clk,
    input  logic                          pdm_data,
    output logic [CHANNELS*OUT_WIDTH-1:0] sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overrun
);
    localparam int HALF = CLK_DIV / 2;
    localparam int CW   = $clog2(CLK_DIV);
    localparam int DW   = $clog2(DECIM);
    localparam int W    = ORDER * $clog2(DECIM) + 2;
    localparam int WCW  = $clog2(ORDER + 1);

    logic [CW-1:0]  cnt_q, cnt_d;
    logic           pclk_q, pclk_d;
    logic [1:0]     sync_q;
    logic [DW-1:0]  dec_q, dec_d;
    logic [WCW-1:0] warm_q, warm_d;
    logic           comb_go_q, comb_go_d, load_go_q, load_go_d;
    logic           valid_q, valid_d, ovr_q, ovr_d;
    logic [CHANNELS-1:0][OUT_WIDTH-1:0] data_q, data_d, res;
    logic           cap_l, per_end, frame;

    assign cap_l   = (cnt_q == CW'(HALF - 1));
    assign per_end = (cnt_q == CW'(CLK_DIV - 1));
    assign frame   = per_end && (dec_q == DW'(DECIM - 1));

    always_comb begin
        cnt_d     = per_end ? '0 : cnt_q + CW'(1);
        // Registered from the next count so pdm_clk tracks cnt >= HALF exactly.
        pclk_d    = (cnt_d >= CW'(HALF));
        dec_d     = dec_q;
        if (per_end)
            dec_d = frame ? '0 : dec_q + DW'(1);
        comb_go_d = frame;
        load_go_d = comb_go_q;

        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        warm_d  = warm_q;
        if (valid_q && sample_ready)
            valid_d = 1'b0;
        if (load_go_q) begin
            // The first ORDER frames are still filling the comb delays.
            if (warm_q != WCW'(ORDER)) begin
                warm_d = warm_q + WCW'(1);
            end else begin
                data_d  = res;
                valid_d = 1'b1;
                if (valid_q && !sample_ready)
                    ovr_d = 1'b1;
            end
        end

        if (!enable) begin
            cnt_d     = '0;
            pclk_d    = 1'b0;
            dec_d     = '0;
            comb_go_d = 1'b0;
            load_go_d = 1'b0;
            data_d    = '0;
            valid_d   = 1'b0;
            ovr_d     = 1'b0;
            warm_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q     <= '0;
            pclk_q    <= 1'b0;
            dec_q     <= '0;
            comb_go_q <= 1'b0;
            load_go_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            warm_q    <= '0;
            sync_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pclk_q    <= pclk_d;
            dec_q     <= dec_d;
            comb_go_q <= comb_go_d;
            load_go_q <= load_go_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            warm_q    <= warm_d;
            sync_q    <= {sync_q[0], pdm_data};
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pdm_cic_chan #(
            .ORDER    (ORDER),
            .W        (W),
            .OUT_WIDTH(OUT_WIDTH)
        ) u_chan (
            .clk    (clk),
            .resetn (resetn),
            .clear_i(!enable),
            .cap_i  ((g == 0) ? cap_l : per_end),
            .bit_i  (sync_q[1]),
            .comb_i (comb_go_q),
            .res_o  (res[g])
        );
    end

    assign pdm_clk      = pclk_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_pdm_cic_recv.sv
// Bench for pdm_cic_recv: a microphone model drives per-period L/R bits from
// tables, and a reference CIC computes each frame as a direct convolution of
// the +/-1 bit stream with the ORDER-fold boxcar impulse response.
module tb_pdm_cic_recv;
    localparam int CHANNELS  = 2;
    localparam int CLK_DIV   = 8;
    localparam int ORDER     = 3;
    localparam int DECIM     = 16;
    localparam int OUT_WIDTH = 12;
    localparam int W     = ORDER * $clog2(DECIM) + 2;
    localparam int SH    = (W > OUT_WIDTH) ? W - OUT_WIDTH : 0;
    localparam int FRAME = CLK_DIV * DECIM;
    localparam int FIRST = (ORDER + 1) * FRAME + 2;
    localparam int H     = ORDER * (DECIM - 1) + 1;
    localparam int NP    = 1024;

    logic clk, resetn, enable, pdm_clk, pdm_data;
    logic sample_valid, sample_ready, overrun;
    logic [CHANNELS*OUT_WIDTH-1:0] sample_data;

    bit lbits [NP];
    bit rbits [NP];
    int hcoef [H];
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pdm_cic_recv #(
        .CHANNELS(CHANNELS), .CLK_DIV(CLK_DIV), .ORDER(ORDER),
        .DECIM(DECIM), .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .pdm_clk(pdm_clk),
        .pdm_data(pdm_data), .sample_data(sample_data),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun)
    );

    // Microphone: L bit after the falling pdm_clk edge, R bit after the rise.
    initial begin : mic
        int prd;
        logic pclk_prev;
        prd = 0;
        pclk_prev = 1'b0;
        pdm_data = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!resetn || !enable) begin
                prd = 0;
                pdm_data = lbits[0];
            end else if (pdm_clk && !pclk_prev) begin
                pdm_data = rbits[prd];
            end else if (!pdm_clk && pclk_prev) begin
                prd = (prd + 1) % NP;
                pdm_data = lbits[prd];
            end
            pclk_prev = pdm_clk;
        end
    end

    task automatic build_h();
        int tmp [H];
        int len;
        foreach (hcoef[i]) hcoef[i] = 0;
        hcoef[0] = 1;
        len = 1;
        repeat (ORDER) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int d = 0; d < DECIM; d++)
                    tmp[i+d] += hcoef[i];
            len += DECIM - 1;
            hcoef = tmp;
        end
    endtask

    // Frame m (1-based) ends at PDM period m*DECIM-1.
    function automatic int exp_val(int ch, int m);
        int y = 0;
        int t = m * DECIM - 1;
        for (int j = 0; j < H; j++)
            if (t - j >= 0)
                y += hcoef[j] * (((ch == 0) ? lbits[t-j] : rbits[t-j]) ? 1 : -1);
        y = y >>> SH;
        return y & ((1 << OUT_WIDTH) - 1);
    endfunction

    function automatic logic [CHANNELS*OUT_WIDTH-1:0] exp_frame(int m);
        logic [CHANNELS*OUT_WIDTH-1:0] f = '0;
        for (int ch = 0; ch < CHANNELS; ch++)
            f[ch*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(exp_val(ch, m));
        return f;
    endfunction

    task automatic fill(input int mode);
        for (int p = 0; p < NP; p++) begin
            case (mode)
                0: begin lbits[p] = 1'b1; rbits[p] = 1'b1; end
                1: begin lbits[p] = 1'b0; rbits[p] = 1'b0; end
                2: begin lbits[p] = 1'b1; rbits[p] = 1'b0; end
                3: begin lbits[p] = (p % 2 == 0); rbits[p] = (p % 2 == 0); end
                default: begin
                    lbits[p] = ($urandom_range(0, 1) == 1);
                    rbits[p] = ($urandom_range(0, 1) == 1);
                end
            endcase
        end
    endtask

    // Leaves enable rising just before cycle 0 of the new run.
    task automatic restart(input int mode);
        @(negedge clk);
        enable = 1'b0;
        fill(mode);
        repeat (3) @(negedge clk);
        enable = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b0;
        sample_ready = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL reset_pdm_clk got %b want 0", pdm_clk); end
        checks++; if (sample_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", sample_data); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        resetn = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL idle_pdm_clk got %b want 0", pdm_clk); end
    endtask

    task automatic test_pdm_clk();
        logic e;
        restart(0);
        for (int c = 1; c <= 3 * CLK_DIV; c++) begin
            @(negedge clk);
            e = ((c % CLK_DIV) >= CLK_DIV / 2);
            checks++;
            if (pdm_clk !== e) begin errors++; $display("FAIL pdm_clk cycle %0d got %b want %b", c, pdm_clk, e); end
        end
    endtask

    task automatic test_stream(input string name, input int mode, input bit has_const,
                               input logic [CHANNELS*OUT_WIDTH-1:0] cval);
        int n;
        logic [CHANNELS*OUT_WIDTH-1:0] e;
        restart(mode);
        sample_ready = 1'b1;
        wait_valid(FIRST + 50, n);
        checks++; if (n != FIRST) begin errors++; $display("FAIL %s_first_latency got %0d want %0d", name, n, FIRST); end
        if (has_const) begin
            checks++; if (sample_data !== cval) begin errors++; $display("FAIL %s_const got %h want %h", name, sample_data, cval); end
        end
        e = exp_frame(ORDER + 1);
        checks++; if (sample_data !== e) begin errors++; $display("FAIL %s_frame%0d got %h want %h", name, ORDER + 1, sample_data, e); end
        for (int m = ORDER + 2; m <= ORDER + 4; m++) begin
            @(negedge clk);
            checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_drop got %b want 0", name, sample_valid); end
            wait_valid(FRAME + 10, n);
            checks++; if (n != FRAME - 1) begin errors++; $display("FAIL %s_frame_spacing got %0d want %0d", name, n, FRAME - 1); end
            e = exp_frame(m);
            checks++; if (sample_data !== e) begin errors++; $display("FAIL %s_frame%0d got %h want %h", name, m, sample_data, e); end
        end
    endtask

    task automatic test_overrun();
        int n;
        logic [CHANNELS*OUT_WIDTH-1:0] e;
        restart(4);
        sample_ready = 1'b1;
        wait_valid(FIRST + 50, n);
        checks++; if (n != FIRST) begin errors++; $display("FAIL ovr_first_latency got %0d want %0d", n, FIRST); end
        @(negedge clk);
        sample_ready = 1'b0;
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b want 0", sample_valid); end
        wait_valid(FRAME + 10, n);
        checks++; if (n != FRAME - 1) begin errors++; $display("FAIL ovr_spacing got %0d want %0d", n, FRAME - 1); end
        e = exp_frame(ORDER + 2);
        checks++; if (sample_data !== e) begin errors++; $display("FAIL ovr_frame5 got %h want %h", sample_data, e); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
        repeat (FRAME / 2) @(negedge clk);
        checks++; if (sample_valid !== 1'b1 || sample_data !== e) begin errors++; $display("FAIL ovr_hold got %b/%h want 1/%h", sample_valid, sample_data, e); end
        repeat (FRAME / 2) @(negedge clk);
        e = exp_frame(ORDER + 3);
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_kept got %b want 1", sample_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        checks++; if (sample_data !== e) begin errors++; $display("FAIL ovr_latest got %h want %h", sample_data, e); end
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept_drop got %b want 0", sample_valid); end
        repeat (5) @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [CHANNELS*OUT_WIDTH-1:0] e;
        restart(4);
        sample_ready = 1'b0;
        wait_valid(FIRST + 50, n);
        e = exp_frame(ORDER + 1);
        checks++; if (n != FIRST || sample_data !== e) begin errors++; $display("FAIL b2b_first got %0d/%h want %0d/%h", n, sample_data, FIRST, e); end
        repeat (FRAME - 1) @(negedge clk);
        checks++; if (sample_valid !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL b2b_held got v%b o%b want v1 o0", sample_valid, overrun); end
        sample_ready = 1'b1;
        @(negedge clk);
        e = exp_frame(ORDER + 2);
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", sample_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
        checks++; if (sample_data !== e) begin errors++; $display("FAIL b2b_data got %h want %h", sample_data, e); end
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", sample_valid); end
    endtask

    task automatic test_async_reset();
        int n;
        logic [CHANNELS*OUT_WIDTH-1:0] e;
        restart(4);
        sample_ready = 1'b0;
        wait_valid(FIRST + 50, n);
        repeat (FRAME) @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL arst_pre_overrun got %b want 1", overrun); end
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            if (pdm_clk) break;
            @(negedge clk);
        end
        checks++; if (pdm_clk !== 1'b1) begin errors++; $display("FAIL arst_pre_pdm_clk got %b want 1", pdm_clk); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL arst_pdm_clk got %b want 0", pdm_clk); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", sample_valid); end
        checks++; if (sample_data !== '0) begin errors++; $display("FAIL arst_data got %h want 0", sample_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL arst_overrun got %b want 0", overrun); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        wait_valid(FIRST + 50, n);
        e = exp_frame(ORDER + 1);
        checks++; if (n != FIRST) begin errors++; $display("FAIL arst_restart_latency got %0d want %0d", n, FIRST); end
        checks++; if (sample_data !== e) begin errors++; $display("FAIL arst_restart_data got %h want %h", sample_data, e); end
    endtask

    task automatic test_enable_drop();
        int n;
        logic [CHANNELS*OUT_WIDTH-1:0] e;
        restart(4);
        sample_ready = 1'b0;
        wait_valid(FIRST + 50, n);
        repeat (FRAME) @(negedge clk);
        checks++; if (overrun !== 1'b1 || sample_valid !== 1'b1) begin errors++; $display("FAIL en_pre got v%b o%b want v1 o1", sample_valid, overrun); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (pdm_clk !== 1'b0) begin errors++; $display("FAIL en_pdm_clk got %b want 0", pdm_clk); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL en_valid got %b want 0", sample_valid); end
        checks++; if (sample_data !== '0) begin errors++; $display("FAIL en_data got %h want 0", sample_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL en_overrun got %b want 0", overrun); end
        fill(4);
        repeat (2) @(negedge clk);
        enable = 1'b1;
        wait_valid(FIRST + 50, n);
        e = exp_frame(ORDER + 1);
        checks++; if (n != FIRST) begin errors++; $display("FAIL en_restart_latency got %0d want %0d", n, FIRST); end
        checks++; if (sample_data !== e) begin errors++; $display("FAIL en_restart_data got %h want %h", sample_data, e); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL en_restart_overrun got %b want 0", overrun); end
    endtask

    initial begin
        build_h();
        test_reset();
        test_pdm_clk();
        test_stream("ones",   0, 1'b1, 24'h400400);
        test_stream("zeros",  1, 1'b1, 24'hC00C00);
        test_stream("l1r0",   2, 1'b1, 24'hC00400);
        test_stream("alt",    3, 1'b1, 24'h000000);
        test_stream("random", 4, 1'b0, 24'h000000);
        test_overrun();
        test_back_to_back();
        test_async_reset();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
